// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags; the producer/consumer side
// uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_flags_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             write_en;
   logic [WIDTH-1:0] data_in;
   logic             read_en;
   logic             err_clr;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output write_en, data_in, read_en, err_clr,
      input  data_out, data_valid, empty, full, almost_empty, almost_full,
             count, overflow, underflow
   );

   modport slave (
      input  write_en, data_in, read_en, err_clr,
      output data_out, data_valid, empty, full, almost_empty, almost_full,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and registered or fall-through read mode.
module sync_fifo_flags #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_flags_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count_w;
   logic             empty_w;
   logic             full_w;
   logic             wr_acc;
   logic             rd_acc;
   logic             overflow_r;
   logic             underflow_r;

   // Pointer width carries one extra wrap bit so full and empty stay distinct.
   assign count_w = wr_ptr - rd_ptr;
   assign empty_w = (wr_ptr == rd_ptr);
   assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign wr_acc = bus.write_en & ~full_w;
   assign rd_acc = bus.read_en  & ~empty_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.data_in;
   end

   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (bus.write_en & full_w)      overflow_r <= 1'b1;
         else if (bus.err_clr)           overflow_r <= 1'b0;
         if (bus.read_en & empty_w)      underflow_r <= 1'b1;
         else if (bus.err_clr)           underflow_r <= 1'b0;
      end
   end

   assign bus.count        = count_w;
   assign bus.empty        = empty_w;
   assign bus.full         = full_w;
   assign bus.almost_full  = (count_w >= AF_T);
   assign bus.almost_empty = (count_w <= AE_T);
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; masked to zero while nothing is stored.
         assign bus.data_out   = empty_w ? '0 : mem[rd_ptr[AW-1:0]];
         assign bus.data_valid = ~empty_w;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_p1;
         logic             vld_p1;

         // p0 -> p1: storage read registered on an accepted pop.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_p1 <= '0;
               vld_p1     <= 1'b0;
            end else begin
               vld_p1 <= rd_acc;
               if (rd_acc) rd_data_p1 <= mem[rd_ptr[AW-1:0]];
            end
         end

         assign bus.data_out   = rd_data_p1;
         assign bus.data_valid = vld_p1;
      end
   endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a registered-read instance and a
// fall-through instance, both DEPTH=16, WIDTH=32.
module tb_sync_fifo_flags;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sync_fifo_flags_if #(.WIDTH(32), .DEPTH(16)) i0 ();
   sync_fifo_flags_if #(.WIDTH(32), .DEPTH(16)) i1 ();

   sync_fifo_flags #(.WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
      dut_std (.clk(clk), .rst(rst), .bus(i0.slave));
   sync_fifo_flags #(.WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
      dut_fw  (.clk(clk), .rst(rst), .bus(i1.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_std(input string tag);
      chk({tag, " count"},  i0.count, 0);
      chk({tag, " empty"},  i0.empty, 1);
      chk({tag, " full"},   i0.full, 0);
      chk({tag, " ae"},     i0.almost_empty, 1);
      chk({tag, " af"},     i0.almost_full, 0);
      chk({tag, " dout"},   i0.data_out, 0);
      chk({tag, " dvalid"}, i0.data_valid, 0);
      chk({tag, " ovf"},    i0.overflow, 0);
      chk({tag, " udf"},    i0.underflow, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int nw, nr, cnt, ph, w, r;
      i0.write_en = 0; i0.data_in = 0; i0.read_en = 0; i0.err_clr = 0;
      i1.write_en = 0; i1.data_in = 0; i1.read_en = 0; i1.err_clr = 0;

      #2;
      chk_reset_std("rst0");
      chk("rst0 fw dvalid", i1.data_valid, 0);
      chk("rst0 fw dout", i1.data_out, 0);
      tick(); tick();
      rst = 0;

      // fill 16 words
      for (int i = 0; i < 16; i++) begin
         i0.write_en = 1; i0.data_in = 32'(i);
         tick();
         chk("fill count", i0.count, 64'(i + 1));
         chk("fill af", i0.almost_full, 64'(i + 1 >= 14));
         chk("fill full", i0.full, 64'(i + 1 == 16));
      end
      i0.write_en = 0;

      // drain 16 words
      for (int i = 0; i < 16; i++) begin
         i0.read_en = 1;
         tick();
         chk("drain data", i0.data_out, 64'(i));
         chk("drain dvalid", i0.data_valid, 1);
         chk("drain count", i0.count, 64'(15 - i));
         chk("drain ae", i0.almost_empty, 64'(15 - i <= 2));
         chk("drain empty", i0.empty, 64'(i == 15));
      end
      i0.read_en = 0;
      tick();
      chk("hold dvalid", i0.data_valid, 0);
      chk("hold dout", i0.data_out, 32'hF);

      // refill, then write+read while full
      for (int i = 0; i < 16; i++) begin
         i0.write_en = 1; i0.data_in = 32'h20 + 32'(i);
         tick();
      end
      chk("refill full", i0.full, 1);
      i0.write_en = 1; i0.read_en = 1; i0.data_in = 32'hAA;
      tick();
      chk("ovf count", i0.count, 15);
      chk("ovf flag", i0.overflow, 1);
      chk("ovf data", i0.data_out, 32'h20);
      chk("ovf full", i0.full, 0);
      i0.write_en = 0; i0.read_en = 0; i0.err_clr = 1;
      tick();
      chk("ovf clr", i0.overflow, 0);
      i0.err_clr = 0;
      for (int i = 1; i < 16; i++) begin
         i0.read_en = 1;
         tick();
         chk("ovf drain", i0.data_out, 64'(32'h20 + 32'(i)));
      end
      i0.read_en = 0;
      tick();
      chk("ovf drained empty", i0.empty, 1);
      chk("ovf drained count", i0.count, 0);

      // underflow from empty
      i0.read_en = 1;
      tick();
      chk("udf flag", i0.underflow, 1);
      chk("udf count", i0.count, 0);
      chk("udf dvalid", i0.data_valid, 0);
      i0.write_en = 1; i0.data_in = 32'h5;
      tick();
      chk("udf wr+rd count", i0.count, 1);
      chk("udf wr+rd dvalid", i0.data_valid, 0);
      i0.write_en = 0; i0.read_en = 1; i0.err_clr = 1;
      tick();
      chk("udf read data", i0.data_out, 32'h5);
      chk("udf read dvalid", i0.data_valid, 1);
      chk("udf clr", i0.underflow, 0);
      i0.err_clr = 1;
      tick();
      chk("udf set wins", i0.underflow, 1);
      i0.read_en = 0;
      tick();
      chk("udf clr2", i0.underflow, 0);
      i0.err_clr = 0;

      // wrap: 40 words with the count kept between 3 and 5
      nw = 0; nr = 0; cnt = 0; ph = 0;
      while (nr < 40) begin
         if (nw < 3) begin
            w = 1; r = 0;
         end else if (nw < 40) begin
            w = ((ph % 5) < 3) ? 1 : 0;
            r = ((ph % 5) >= 2) ? 1 : 0;
            ph++;
         end else begin
            w = 0; r = 1;
         end
         i0.write_en = w[0]; i0.read_en = r[0]; i0.data_in = 32'h100 + 32'(nw);
         tick();
         cnt = cnt + w - r;
         chk("wrap count", i0.count, 64'(cnt));
         chk("wrap ae", i0.almost_empty, 64'(cnt <= 2));
         chk("wrap dvalid", i0.data_valid, 64'(r));
         if (r == 1) begin
            chk("wrap data", i0.data_out, 64'(32'h100 + 32'(nr)));
            nr++;
         end
         if (w == 1) nw++;
      end
      i0.write_en = 0; i0.read_en = 0;

      // fall-through instance
      i1.write_en = 1; i1.data_in = 32'h11;
      tick();
      chk("fw first dout", i1.data_out, 32'h11);
      chk("fw first dvalid", i1.data_valid, 1);
      i1.data_in = 32'h22;
      tick();
      chk("fw count2", i1.count, 2);
      chk("fw head held", i1.data_out, 32'h11);
      i1.write_en = 0; i1.read_en = 1;
      tick();
      chk("fw pop dout", i1.data_out, 32'h22);
      chk("fw pop dvalid", i1.data_valid, 1);
      tick();
      chk("fw empty dvalid", i1.data_valid, 0);
      chk("fw empty", i1.empty, 1);
      i1.read_en = 0;

      // reset mid-stream at count 7
      for (int i = 0; i < 7; i++) begin
         i0.write_en = 1; i0.data_in = 32'h70 + 32'(i);
         i0.read_en = (i == 0);
         tick();
      end
      i0.write_en = 0; i0.read_en = 0;
      i0.read_en = 1; i0.write_en = 1; i0.data_in = 32'h77;
      tick();
      i0.read_en = 0; i0.write_en = 0;
      chk("pre-rst count", i0.count, 7);
      chk("pre-rst dout", i0.data_out, 32'h70);
      rst = 1;
      #2;
      chk_reset_std("rst mid");
      tick();
      rst = 0; i0.write_en = 1; i0.data_in = 32'h3C;
      tick();
      chk("post-rst count", i0.count, 1);
      i0.write_en = 0; i0.read_en = 1;
      tick();
      chk("post-rst data", i0.data_out, 32'h3C);
      chk("post-rst dvalid", i0.data_valid, 1);
      chk("post-rst empty", i0.empty, 1);
      i0.read_en = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
